// File: rtl/fft32_addr_ctrl_if.sv
// Connection bundle between the FFT address sequencer and the butterfly/memory side.
// The master modport belongs to the sequencer; the slave modport belongs to its consumer.
interface fft32_addr_ctrl_if;
  logic       start;
  logic       bf_ready;
  logic       rd_valid;
  logic [4:0] rd_addr_a;
  logic [4:0] rd_addr_b;
  logic [3:0] tw_addr;
  logic       wr_en;
  logic [4:0] wr_addr_a;
  logic [4:0] wr_addr_b;
  logic [2:0] stage;
  logic       busy;
  logic       done;

  modport master (
    input  start, bf_ready,
    output rd_valid, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b, stage, busy, done
  );

  modport slave (
    output start, bf_ready,
    input  rd_valid, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b, stage, busy, done
  );
endinterface

// File: rtl/fft32_addr_ctrl.sv
// Address sequencer for a 32-point radix-2 DIT FFT: 5 stages x 16 butterflies.
// Read addresses are replayed as write-back addresses BFLY_LAT cycles later.
//
// state | meaning
// IDLE  | waiting for start, all outputs quiet
// ISSUE | issuing one butterfly per cycle while bf_ready is high
// DRAIN | all reads of the stage issued, waiting for the last write-back
// DONE  | one-cycle completion pulse, then back to IDLE
module fft32_addr_ctrl #(
  parameter int BFLY_LAT = 4
) (
  input logic                clk,
  input logic                rst,
  fft32_addr_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [3:0]          bcnt;
  logic [2:0]          stage_q;
  logic [4:0]          inflight;
  logic [BFLY_LAT:0]   v_pipe;
  logic [4:0]          a_pipe [0:BFLY_LAT];
  logic [4:0]          b_pipe [0:BFLY_LAT];
  logic [3:0]          tw_q;
  logic                done_q;
  logic                busy_q;

  logic                issue;
  logic                drain_exit;
  logic [4:0]          h, p, g, a_calc, b_calc;
  logic [3:0]          tw_calc;
  logic                rd_valid_d, done_d, busy_d;
  logic [4:0]          a_d, b_d;
  logic [3:0]          tw_d;

  assign issue = (state == ISSUE) && bus.bf_ready;
  // v_pipe[BFLY_LAT-1] becomes wr_en on the next edge; with one read left in flight that is the last write.
  assign drain_exit = (state == DRAIN) && (inflight == 5'd1) && v_pipe[BFLY_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = ISSUE;
      ISSUE: if (bus.bf_ready && bcnt == 4'd15) state_nxt = DRAIN;
      DRAIN: if (drain_exit) state_nxt = (stage_q == 3'd4) ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    h       = 5'd1 << stage_q;
    p       = {1'b0, bcnt} & (h - 5'd1);
    g       = {1'b0, bcnt} >> stage_q;
    a_calc  = (g << (stage_q + 3'd1)) | p;
    b_calc  = a_calc + h;
    tw_calc = p[3:0] << (3'd4 - stage_q);
  end

  always_comb begin
    rd_valid_d = issue;
    a_d        = a_pipe[0];
    b_d        = b_pipe[0];
    tw_d       = tw_q;
    if (issue) begin
      a_d  = a_calc;
      b_d  = b_calc;
      tw_d = tw_calc;
    end
    done_d = (state == DONE);
    // Keep busy through the done cycle so it falls together with done.
    busy_d = (state_nxt != IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_pipe <= '0;
      tw_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      for (int k = 0; k <= BFLY_LAT; k++) begin
        a_pipe[k] <= '0;
        b_pipe[k] <= '0;
      end
    end else begin
      v_pipe <= {v_pipe[BFLY_LAT-1:0], rd_valid_d};
      for (int k = BFLY_LAT; k >= 1; k--) begin
        a_pipe[k] <= a_pipe[k-1];
        b_pipe[k] <= b_pipe[k-1];
      end
      a_pipe[0] <= a_d;
      b_pipe[0] <= b_d;
      tw_q      <= tw_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt     <= '0;
      stage_q  <= '0;
      inflight <= '0;
    end else begin
      inflight <= inflight + {4'b0, issue} - {4'b0, v_pipe[BFLY_LAT-1]};
      case (state)
        IDLE: if (bus.start) begin
          bcnt    <= '0;
          stage_q <= '0;
        end
        ISSUE: if (bus.bf_ready) bcnt <= bcnt + 4'd1;
        DRAIN: if (drain_exit && stage_q != 3'd4) begin
          stage_q <= stage_q + 3'd1;
          bcnt    <= '0;
        end
        DONE: stage_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.rd_valid  = v_pipe[0];
  assign bus.rd_addr_a = a_pipe[0];
  assign bus.rd_addr_b = b_pipe[0];
  assign bus.tw_addr   = tw_q;
  assign bus.wr_en     = v_pipe[BFLY_LAT];
  assign bus.wr_addr_a = a_pipe[BFLY_LAT];
  assign bus.wr_addr_b = b_pipe[BFLY_LAT];
  assign bus.stage     = stage_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fft32_addr_ctrl.sv
// Directed bench for fft32_addr_ctrl: full transforms, stalls, stage hazards, reset abort, held start.
// Cycle n is the interval after rising edge n, where start is sampled at edge 0.
module tb_fft32_addr_ctrl;
  localparam int L = 4;

  typedef struct {
    int         cyc;
    int         s;
    logic [4:0] a;
    logic [4:0] b;
  } rd_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fft32_addr_ctrl_if bus();

  fft32_addr_ctrl #(.BFLY_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b-th index of the stage whose bit s is clear: the top operand of butterfly b.
  function automatic logic [4:0] exp_top(input int s, input int b);
    int         cnt;
    logic [4:0] r;
    cnt = 0;
    r   = '0;
    for (int i = 0; i < 32; i++) begin
      if (((i >> s) & 1) == 0) begin
        if (cnt == b) r = i[4:0];
        cnt++;
      end
    end
    return r;
  endfunction

  function automatic logic [30:0] all_out();
    return {bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_en,
            bus.wr_addr_a, bus.wr_addr_b, bus.stage, bus.busy, bus.done};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.bf_ready = 1'b0;
    tick();
    tick();
    total++;
    if (all_out() !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out());
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_run(input bit stall);
    rd_t        q[$];
    rd_t        e;
    rd_t        r;
    logic [4:0] cap_a [80];
    logic [4:0] cap_b [80];
    logic [3:0] cap_t [80];
    int         cap_c [80];
    logic [31:0] seen [5];
    int rd_idx, done_cnt, done_cyc, busy_low, last_w0, first_r1, first_w, exp_done, sh;
    int s, b, twi;
    logic [4:0] ea, eb;
    logic [3:0] et;
    rd_idx = 0; done_cnt = 0; done_cyc = -1; busy_low = -1;
    last_w0 = -1; first_r1 = -1; first_w = -1;
    sh = stall ? 3 : 0;
    exp_done = 101 + sh;
    for (int k = 0; k < 5; k++) seen[k] = '0;
    for (int k = 0; k < 80; k++) begin
      cap_a[k] = '0; cap_b[k] = '0; cap_t[k] = '0; cap_c[k] = -1;
    end

    bus.bf_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", bus.busy);
    end

    for (int n = 1; n <= 250 && busy_low < 0; n++) begin
      bus.bf_ready = !(stall && n >= 9 && n <= 11);
      tick();
      if (stall && n >= 9 && n <= 11) begin
        total++;
        if (bus.rd_valid !== 1'b0) begin
          bad++;
          $display("FAIL stall_rd_valid cyc %0d: got %b want 0", n, bus.rd_valid);
        end
      end
      if (bus.rd_valid === 1'b1) begin
        total++;
        if (rd_idx >= 80) begin
          bad++;
          $display("FAIL extra_read cyc %0d: got read %0d want at most 80", n, rd_idx + 1);
        end else begin
          s   = rd_idx / 16;
          b   = rd_idx % 16;
          ea  = exp_top(s, b);
          eb  = 5'(int'(ea) + (1 << s));
          twi = (int'(ea) % (1 << s)) * (16 >> s);
          et  = twi[3:0];
          if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage} !== {ea, eb, et, 3'(s)}) begin
            bad++;
            $display("FAIL read_tuple s%0d b%0d: got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                     s, b, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage, ea, eb, et, s);
          end
          total++;
          if (seen[s][bus.rd_addr_a] || seen[s][bus.rd_addr_b]) begin
            bad++;
            $display("FAIL dup_index s%0d: got a=%0d b=%0d want unused", s, bus.rd_addr_a, bus.rd_addr_b);
          end
          seen[s][bus.rd_addr_a] = 1'b1;
          seen[s][bus.rd_addr_b] = 1'b1;
          total++;
          if (q.size() > 0 && q[0].s < s) begin
            bad++;
            $display("FAIL hazard cyc %0d: got pending stage %0d want none before %0d", n, q[0].s, s);
          end
          cap_a[rd_idx] = bus.rd_addr_a;
          cap_b[rd_idx] = bus.rd_addr_b;
          cap_t[rd_idx] = bus.tw_addr;
          cap_c[rd_idx] = n;
          if (s == 1 && first_r1 < 0) first_r1 = n;
          r.cyc = n; r.s = s; r.a = bus.rd_addr_a; r.b = bus.rd_addr_b;
          q.push_back(r);
        end
        rd_idx++;
      end
      if (bus.wr_en === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL wr_orphan cyc %0d: got wr_en 1 want 0", n);
        end else begin
          e = q.pop_front();
          if (n != e.cyc + L || bus.wr_addr_a !== e.a || bus.wr_addr_b !== e.b) begin
            bad++;
            $display("FAIL write_replay cyc %0d: got a=%0d b=%0d want a=%0d b=%0d at cyc %0d",
                     n, bus.wr_addr_a, bus.wr_addr_b, e.a, e.b, e.cyc + L);
          end
          if (e.s == 0) last_w0 = n;
          if (first_w < 0) first_w = n;
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = n;
        total++;
        if (bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_at_done: got %b want 1", bus.busy);
        end
      end
      if (bus.busy === 1'b0) begin
        busy_low = n;
        total++;
        if (bus.stage !== 3'd0) begin
          bad++;
          $display("FAIL stage_idle: got %0d want 0", bus.stage);
        end
      end
    end

    total++;
    if (rd_idx != 80) begin bad++; $display("FAIL read_count: got %0d want 80", rd_idx); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL done_count: got %0d want 1", done_cnt); end
    total++;
    if (done_cyc != exp_done) begin bad++; $display("FAIL done_cycle: got %0d want %0d", done_cyc, exp_done); end
    total++;
    if (busy_low != exp_done + 1) begin bad++; $display("FAIL busy_low_cycle: got %0d want %0d", busy_low, exp_done + 1); end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL writes_pending: got %0d want 0", q.size()); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (seen[k] !== 32'hffff_ffff) begin
        bad++;
        $display("FAIL coverage s%0d: got %h want ffffffff", k, seen[k]);
      end
    end
    total++;
    if (cap_c[0] != 1 || {cap_a[0], cap_b[0], cap_t[0]} !== {5'd0, 5'd1, 4'd0}) begin
      bad++;
      $display("FAIL first_read: got cyc=%0d a=%0d b=%0d tw=%0d want cyc=1 a=0 b=1 tw=0",
               cap_c[0], cap_a[0], cap_b[0], cap_t[0]);
    end
    total++;
    if (first_w != 5) begin bad++; $display("FAIL first_write_cycle: got %0d want 5", first_w); end
    total++;
    if ({cap_a[17], cap_b[17], cap_t[17]} !== {5'd1, 5'd3, 4'd8}) begin
      bad++;
      $display("FAIL vec_s1b1: got a=%0d b=%0d tw=%0d want 1 3 8", cap_a[17], cap_b[17], cap_t[17]);
    end
    total++;
    if ({cap_a[38], cap_b[38], cap_t[38]} !== {5'd10, 5'd14, 4'd8}) begin
      bad++;
      $display("FAIL vec_s2b6: got a=%0d b=%0d tw=%0d want 10 14 8", cap_a[38], cap_b[38], cap_t[38]);
    end
    total++;
    if ({cap_a[69], cap_b[69], cap_t[69]} !== {5'd5, 5'd21, 4'd5}) begin
      bad++;
      $display("FAIL vec_s4b5: got a=%0d b=%0d tw=%0d want 5 21 5", cap_a[69], cap_b[69], cap_t[69]);
    end
    total++;
    if (last_w0 != 20 + sh) begin bad++; $display("FAIL last_s0_write: got %0d want %0d", last_w0, 20 + sh); end
    total++;
    if (first_r1 != 21 + sh) begin bad++; $display("FAIL first_s1_read: got %0d want %0d", first_r1, 21 + sh); end
    total++;
    if (cap_c[8] != 9 + sh || cap_c[7] != 8 || {cap_a[8], cap_b[8]} !== {5'd16, 5'd17}) begin
      bad++;
      $display("FAIL read_b8: got cyc=%0d a=%0d b=%0d want cyc=%0d a=16 b=17",
               cap_c[8], cap_a[8], cap_b[8], 9 + sh);
    end
  endtask

  task automatic test_reset_mid();
    int hits;
    int waited;
    bus.bf_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 1; n <= 50; n++) tick();
    total++;
    if (bus.stage !== 3'd2) begin bad++; $display("FAIL mid_stage: got %0d want 2", bus.stage); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (all_out() !== 31'd0) begin bad++; $display("FAIL abort_outputs: got %h want 0", all_out()); end
    #2 rst = 1'b1;
    hits = 0;
    for (int n = 0; n < 120; n++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1 || bus.rd_valid === 1'b1 || bus.wr_en === 1'b1) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", hits); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage} !== {1'b1, 5'd0, 5'd1, 4'd0, 3'd0}) begin
      bad++;
      $display("FAIL restart_read: got v=%b a=%0d b=%0d tw=%0d st=%0d want v=1 a=0 b=1 tw=0 st=0",
               bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage);
    end
    waited = 0;
    while (bus.busy === 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL restart_finish: got busy %b want 0", bus.busy); end
  endtask

  task automatic test_start_held();
    int d_cnt, entries;
    int d_cyc [4];
    d_cnt = 0;
    entries = 0;
    for (int k = 0; k < 4; k++) d_cyc[k] = -1;
    bus.bf_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    for (int n = 1; n <= 260; n++) begin
      if (n >= 180)      bus.start = 1'b0;
      else if (n >= 150) bus.start = n[0];
      tick();
      if (bus.done === 1'b1) begin
        if (d_cnt < 4) d_cyc[d_cnt] = n;
        d_cnt++;
      end
      if (bus.rd_valid === 1'b1 && bus.stage === 3'd0 && bus.rd_addr_a === 5'd0 && bus.rd_addr_b === 5'd1)
        entries++;
    end
    total++;
    if (d_cnt != 2) begin bad++; $display("FAIL held_done_count: got %0d want 2", d_cnt); end
    total++;
    if (d_cyc[0] != 101 || d_cyc[1] != 203) begin
      bad++;
      $display("FAIL held_done_cycles: got %0d,%0d want 101,203", d_cyc[0], d_cyc[1]);
    end
    total++;
    if (entries != 2) begin bad++; $display("FAIL held_entries: got %0d want 2", entries); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL held_final_busy: got %b want 0", bus.busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.bf_ready = 1'b0;
    test_reset();
    test_run(1'b0);
    test_run(1'b1);
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
